// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin, packet-granular sharing of one UART
// transmitter between NUM_REQ requesters.
//
// Ports:
//   clk_3125   in   system clock (3.125 MHz)
//   reset      in   synchronous active-high reset
//   req        in   [NUM_REQ]    per-requester request, held for the whole packet
//   req_data   in   [8*NUM_REQ]  byte of requester i on bits [8i+7:8i]
//   req_last   in   [NUM_REQ]    current byte of requester i ends its packet
//   req_ack    out  [NUM_REQ]    one-cycle pulse: current byte accepted
//   grant      out  [NUM_REQ]    one-hot current owner, zero when unowned
//   tx_start   out               one-cycle start pulse to the transmitter
//   tx_data    out  [8]          byte to transmit, held until the next tx_start
//   tx_done    in                transmitter end-of-stop-bit pulse
//   busy       out               high in any state other than IDLE
//   err        out               one-cycle pulse on timeout or mid-packet withdrawal
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned GAP_CYCLES = 14,
  parameter int unsigned TX_TIMEOUT = 200
) (
  input  logic                 clk_3125,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SUM_W = IDX_W + 1;
  localparam int unsigned TO_W  = $clog2(TX_TIMEOUT);
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t             state_q,    state_d;
  logic [NUM_REQ-1:0] grant_q,    grant_d;
  logic [NUM_REQ-1:0] req_ack_q,  req_ack_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q,  tx_data_d;
  logic               busy_q,     busy_d;
  logic               err_q,      err_d;
  logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
  logic [IDX_W-1:0]   winner_q,   winner_d;
  logic               last_q,     last_d;
  logic               sent_q,     sent_d;
  logic [TO_W-1:0]    to_cnt_q,   to_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q,  gap_cnt_d;

  logic [7:0]         data_arr [NUM_REQ];
  logic               arb_found_c;
  logic [IDX_W-1:0]   arb_idx_c;
  logic [SUM_W-1:0]   sum_c;

  // Unpack the flat request-data bus into per-requester bytes.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[8*i +: 8];
    end
  end

  // Round-robin search starting just after the last finished owner.
  always_comb begin
    arb_found_c = 1'b0;
    arb_idx_c   = rr_ptr_q;
    sum_c       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      sum_c = SUM_W'(rr_ptr_q) + SUM_W'(k);
      if (sum_c >= SUM_W'(NUM_REQ)) begin
        sum_c = sum_c - SUM_W'(NUM_REQ);
      end
      if (!arb_found_c && req[sum_c[IDX_W-1:0]]) begin
        arb_found_c = 1'b1;
        arb_idx_c   = sum_c[IDX_W-1:0];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    req_ack_d  = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    err_d      = 1'b0;
    rr_ptr_d   = rr_ptr_q;
    winner_d   = winner_q;
    last_d     = last_q;
    sent_d     = sent_q;
    to_cnt_d   = to_cnt_q;
    gap_cnt_d  = gap_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (arb_found_c) begin
          winner_d            = arb_idx_c;
          grant_d             = '0;
          grant_d[arb_idx_c]  = 1'b1;
          sent_d              = 1'b0;
          state_d             = S_LOAD;
        end
      end

      S_LOAD: begin
        if (req[winner_q]) begin
          tx_start_d          = 1'b1;
          tx_data_d           = data_arr[winner_q];
          req_ack_d[winner_q] = 1'b1;
          last_d              = req_last[winner_q];
          to_cnt_d            = '0;
          sent_d              = 1'b1;
          state_d             = S_SEND;
        end else begin
          grant_d = '0;
          if (sent_q) begin
            // Withdrawn mid-packet: flag it and treat as a finished packet.
            err_d    = 1'b1;
            rr_ptr_d = winner_q;
            if (GAP_CYCLES == 0) begin
              state_d = S_IDLE;
            end else begin
              gap_cnt_d = '0;
              state_d   = S_GAP;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_SEND: begin
        if (tx_done) begin
          if (last_q) begin
            grant_d  = '0;
            rr_ptr_d = winner_q;
            if (GAP_CYCLES == 0) begin
              state_d = S_IDLE;
            end else begin
              gap_cnt_d = '0;
              state_d   = S_GAP;
            end
          end else begin
            state_d = S_LOAD;
          end
        end else if (to_cnt_q == TO_W'(TX_TIMEOUT - 1)) begin
          err_d    = 1'b1;
          grant_d  = '0;
          rr_ptr_d = winner_q;
          if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_3125) begin
    if (reset) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      req_ack_q  <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
      winner_q   <= '0;
      last_q     <= 1'b0;
      sent_q     <= 1'b0;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      req_ack_q  <= req_ack_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      rr_ptr_q   <= rr_ptr_d;
      winner_q   <= winner_d;
      last_q     <= last_d;
      sent_q     <= sent_d;
      to_cnt_q   <= to_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign grant    = grant_q;
  assign req_ack  = req_ack_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

  localparam int N   = 3;
  localparam int GAP = 14;
  localparam int TO  = 200;

  logic           clk_3125 = 1'b0;
  logic           reset    = 1'b1;
  logic [N-1:0]   req      = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   grant;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_done  = 1'b0;
  logic           busy;
  logic           err;

  always #5 clk_3125 = ~clk_3125;

  uart_tx_scheduler #(.NUM_REQ(N), .GAP_CYCLES(GAP), .TX_TIMEOUT(TO)) dut (
    .clk_3125 (clk_3125),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .req_ack  (req_ack),
    .grant    (grant),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .busy     (busy),
    .err      (err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;   // index of the next rising edge

  // Reference model: owner, cycle-stamped deadlines, packet bookkeeping.
  int   m_owner, m_rr, m_idle_from, m_start_cyc;
  bit   m_want, m_last, m_sent;
  logic [N-1:0] e_grant, e_ack;
  logic         e_start, e_busy, e_err;
  logic [7:0]   e_data;

  // Observed-event logs.
  int          n_start, n_err, start_cyc_log, err_cyc_log;
  logic [7:0]  start_data[$];
  logic [N-1:0] start_grant[$];
  int          grant_order[$];
  int          grant_cycs[$];
  int          drop_cycs[$];
  logic [N-1:0] prev_grant = '0;

  // Requester and transmitter stimulus engine.
  bit         act[N];
  int         plen[N];
  int         pidx[N];
  logic [7:0] pbytes[N][8];
  int         tx_due  = -1;
  int         tx_mode = 0;
  bit         rnd_mode = 0;
  bit         refill   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  task automatic finish_pkt();
    m_rr        = m_owner;
    m_owner     = -1;
    m_want      = 0;
    m_idle_from = cyc + 1 + GAP;
  endtask

  // Outputs expected after edge 'cyc', from the inputs sampled at it.
  task automatic model_step();
    int w;
    e_ack   = '0;
    e_start = 1'b0;
    e_err   = 1'b0;
    if (reset) begin
      m_owner = -1; m_rr = N - 1; m_idle_from = cyc + 1;
      m_want = 0; m_sent = 0; m_last = 0; e_data = 8'h00;
    end else if (m_owner < 0) begin
      if (cyc >= m_idle_from && req != '0) begin
        w = -1;
        for (int k = 1; k <= N; k++) if (w < 0 && req[(m_rr + k) % N]) w = (m_rr + k) % N;
        m_owner = w; m_want = 1; m_sent = 0;
      end
    end else if (m_want) begin
      if (req[m_owner]) begin
        e_start = 1'b1;
        e_data  = req_data[8*m_owner +: 8];
        e_ack[m_owner] = 1'b1;
        m_last = req_last[m_owner]; m_start_cyc = cyc; m_want = 0; m_sent = 1;
      end else if (!m_sent) begin
        m_owner = -1; m_want = 0; m_idle_from = cyc + 1;
      end else begin
        e_err = 1'b1;
        finish_pkt();
      end
    end else begin
      if (tx_done) begin
        if (m_last) finish_pkt();
        else m_want = 1;
      end else if (cyc - m_start_cyc == TO) begin
        e_err = 1'b1;
        finish_pkt();
      end
    end
    e_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e_busy  = (m_owner >= 0) || (cyc + 1 < m_idle_from);
  endtask

  task automatic check_outputs();
    chk("grant",    32'(grant),    32'(e_grant));
    chk("req_ack",  32'(req_ack),  32'(e_ack));
    chk("tx_start", 32'(tx_start), 32'(e_start));
    chk("tx_data",  32'(tx_data),  32'(e_data));
    chk("busy",     32'(busy),     32'(e_busy));
    chk("err",      32'(err),      32'(e_err));
  endtask

  task automatic log_events();
    if (tx_start === 1'b1) begin
      n_start++; start_cyc_log = cyc;
      start_data.push_back(tx_data); start_grant.push_back(grant);
    end
    if (err === 1'b1) begin n_err++; err_cyc_log = cyc; end
    if (grant != '0 && prev_grant == '0) begin
      for (int i = 0; i < N; i++) if (grant[i]) grant_order.push_back(i);
      grant_cycs.push_back(cyc);
    end
    if (grant == '0 && prev_grant != '0) drop_cycs.push_back(cyc);
    prev_grant = grant;
  endtask

  task automatic clear_logs();
    n_start = 0; n_err = 0; start_cyc_log = -1; err_cyc_log = -1;
    start_data.delete(); start_grant.delete(); grant_order.delete();
    grant_cycs.delete(); drop_cycs.delete();
  endtask

  task automatic tick();
    @(posedge clk_3125);
    model_step();
    #1;
    check_outputs();
    log_events();
    cyc++;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req[i]      = act[i];
      req_last[i] = act[i] && (pidx[i] == plen[i] - 1);
      req_data[8*i +: 8] = act[i] ? pbytes[i][pidx[i]] : 8'h00;
    end
  endtask

  task automatic new_pkt(input int i, input int len, input logic [63:0] b);
    act[i] = 1; plen[i] = len; pidx[i] = 0;
    for (int k = 0; k < 8; k++) pbytes[i][k] = b[8*k +: 8];
    drive_inputs();
  endtask

  // React to the outputs just observed and set up inputs for the next edge.
  task automatic react();
    int d;
    int r;
    for (int i = 0; i < N; i++) begin
      if (req_ack[i] === 1'b1 && act[i]) begin
        pidx[i]++;
        if (pidx[i] >= plen[i]) begin
          act[i] = 0;
          if (refill) new_pkt(i, 1, 64'(8'h30 + i));
        end
      end
    end
    if (tx_start === 1'b1) begin
      if (tx_mode > 0) d = tx_mode;
      else if (tx_mode < 0) d = -1;
      else begin
        r = $urandom_range(99, 0);
        if (r < 70) d = $urandom_range(20, 1);
        else if (r < 92) d = $urandom_range(170, 140);
        else d = -1;
      end
      tx_due = (d < 0) ? -1 : cyc - 1 + d;
    end
    tx_done = (cyc == tx_due);
    if (rnd_mode) begin
      if ($urandom_range(59, 0) == 0) tx_done = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (!act[i]) begin
          if ($urandom_range(19, 0) == 0) new_pkt(i, $urandom_range(4, 1), {$urandom, $urandom});
        end else if ($urandom_range(499, 0) == 0) begin
          act[i] = 0;
        end
      end
      reset = ($urandom_range(2499, 0) == 0);
    end
    drive_inputs();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin tick(); react(); end
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) act[i] = 0;
    rnd_mode = 0; refill = 0; tx_due = -1;
    drive_inputs();
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    tx_done = 1'b0;
    clear_logs();
  endtask

  initial begin
    int t0;

    // Single byte with a transmitter that finishes 155 cycles after start.
    do_reset();
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    tx_mode = 155;
    t0 = cyc;
    new_pkt(0, 1, 64'h52);
    tick(); react();
    chk("a_grant_c1", 32'(grant), 32'b001);
    tick(); react();
    chk("a_start_c2", 32'(tx_start), 32'd1);
    chk("a_data_c2",  32'(tx_data),  32'h52);
    chk("a_ack_c2",   32'(req_ack),  32'b001);
    while (cyc <= t0 + 156) begin tick(); react(); end
    chk("a_grant_c157", 32'(grant), 32'd0);
    while (cyc <= t0 + 169) begin tick(); react(); end
    chk("a_busy_c170", 32'(busy), 32'd1);
    tick(); react();
    chk("a_busy_c171", 32'(busy), 32'd0);

    // Round robin with three continuous one-byte requesters.
    do_reset();
    tx_mode = 5; refill = 1;
    for (int i = 0; i < N; i++) new_pkt(i, 1, 64'(8'h30 + i));
    for (int k = 0; k < 400 && grant_order.size() < 4; k++) begin tick(); react(); end
    chk("b_ngrants", 32'(grant_order.size()), 32'd4);
    chk("b_order0", 32'(grant_order[0]), 32'd0);
    chk("b_order1", 32'(grant_order[1]), 32'd1);
    chk("b_order2", 32'(grant_order[2]), 32'd2);
    chk("b_order3", 32'(grant_order[3]), 32'd0);
    chk("b_gap", 32'(grant_cycs[1] - drop_cycs[0]), 32'd15);

    // Multi-byte packet keeps the grant while requester 0 waits.
    do_reset();
    tx_mode = 8;
    new_pkt(1, 3, 64'h424752);
    for (int k = 0; k < 20 && n_start < 1; k++) begin tick(); react(); end
    new_pkt(0, 1, 64'h99);
    for (int k = 0; k < 300 && grant_order.size() < 2; k++) begin tick(); react(); end
    chk("c_nstart", 32'(start_data.size() >= 3), 32'd1);
    chk("c_d0", 32'(start_data[0]), 32'h52);
    chk("c_d1", 32'(start_data[1]), 32'h47);
    chk("c_d2", 32'(start_data[2]), 32'h42);
    chk("c_g2", 32'(start_grant[2]), 32'b010);
    chk("c_order0", 32'(grant_order[0]), 32'd1);
    chk("c_order1", 32'(grant_order[1]), 32'd0);
    chk("c_gap", 32'(grant_cycs[1] - drop_cycs[0]), 32'd15);

    // Timeout on requester 2, then arbitration resumes at requester 0.
    do_reset();
    tx_mode = -1;
    new_pkt(2, 1, 64'hA5);
    for (int k = 0; k < 300 && n_err < 1; k++) begin tick(); react(); end
    chk("d_err_seen", 32'(n_err), 32'd1);
    chk("d_err_delay", 32'(err_cyc_log - start_cyc_log), 32'd200);
    chk("d_grant0", 32'(grant), 32'd0);
    tx_mode = 5;
    for (int i = 0; i < N; i++) new_pkt(i, 1, 64'(8'h60 + i));
    for (int k = 0; k < 100 && grant_order.size() < 2; k++) begin tick(); react(); end
    chk("d_next", 32'(grant_order[1]), 32'd0);

    // Withdrawal after the first byte, then before any byte.
    do_reset();
    tx_mode = 6;
    new_pkt(0, 2, 64'h2211);
    for (int k = 0; k < 20 && n_start < 1; k++) begin tick(); react(); end
    act[0] = 0; drive_inputs();
    run(30);
    chk("e_nstart", 32'(n_start), 32'd1);
    chk("e_nerr",   32'(n_err),   32'd1);
    clear_logs();
    new_pkt(0, 1, 64'h33);
    tick(); react();
    chk("e2_grant", 32'(grant), 32'b001);
    act[0] = 0; drive_inputs();
    tick(); react();
    chk("e2_grant_drop", 32'(grant), 32'd0);
    chk("e2_busy", 32'(busy), 32'd0);
    run(5);
    chk("e2_nerr",   32'(n_err),   32'd0);
    chk("e2_nstart", 32'(n_start), 32'd0);

    // Reset mid-SEND, then spurious tx_done in IDLE and in GAP.
    do_reset();
    tx_mode = -1;
    new_pkt(1, 1, 64'h77);
    for (int k = 0; k < 20 && n_start < 1; k++) begin tick(); react(); end
    run(10);
    reset = 1'b1;
    tick(); react();
    reset = 1'b0;
    chk("f_grant", 32'(grant),    32'd0);
    chk("f_busy",  32'(busy),     32'd0);
    chk("f_data",  32'(tx_data),  32'd0);
    chk("f_start", 32'(tx_start), 32'd0);
    tx_done = 1'b1;
    tick(); react();
    chk("f_idle_done_busy", 32'(busy), 32'd0);
    clear_logs();
    tx_mode = 4;
    new_pkt(2, 1, 64'h66);
    for (int k = 0; k < 60 && drop_cycs.size() < 1; k++) begin tick(); react(); end
    chk("f_dropped", 32'(drop_cycs.size()), 32'd1);
    tx_done = 1'b1;
    tick();
    chk("f_gap_done_busy",  32'(busy),  32'd1);
    chk("f_gap_done_grant", 32'(grant), 32'd0);
    react();
    run(20);

    // Randomized traffic.
    do_reset();
    tx_mode = 0; rnd_mode = 1;
    run(20000);
    rnd_mode = 0; reset = 1'b0;
    run(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART transmitter (11-bit frame: start, 8 data, parity, stop; 14 clk_3125 cycles per bit) between NUM_REQ requesters, e.g. colour-sensor report, status, debug echo.
- Round-robin arbitration at packet granularity: a granted requester keeps the transmitter until its byte flagged last has been sent.
- Sequences each byte into the transmitter with a start/done handshake, enforces an inter-packet idle gap, and aborts on a transmitter timeout.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- GAP_CYCLES, 14, idle cycles after each packet before re-arbitration (0 = no gap).
- TX_TIMEOUT, 200, max cycles in SEND waiting for tx_done before abort (must exceed 11*14).

Ports:
- clk_3125  in  1  3.125 MHz system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held high for the whole packet.
- req_data  in  8*NUM_REQ  byte of requester i on bits [8i+7:8i]; stable while req[i] is high and until its ack.
- req_last  in  NUM_REQ  current byte of requester i is the final byte of its packet.
- req_ack  out  NUM_REQ  one-cycle pulse: requester's current byte accepted; next byte/last may be presented the following cycle.
- grant  out  NUM_REQ  one-hot current owner; all-zero when unowned.
- tx_start  out  1  one-cycle pulse to the transmitter.
- tx_data  out  8  byte to transmit; valid from tx_start, held until next tx_start.
- tx_done  in  1  one-cycle pulse from the transmitter at end of stop bit.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle pulse on timeout or mid-packet withdrawal.

Behaviour:
- One clock domain. Reset is synchronous and active-high; all outputs are registered. Reset values: grant=0, req_ack=0, tx_start=0, tx_data=0, busy=0, err=0, state=IDLE, rr_ptr=NUM_REQ-1.
- Reset mid-packet returns to IDLE immediately with no err pulse; the transmitter is not notified.
- States: IDLE, LOAD, SEND, GAP.
- IDLE, when req!=0:
  - winner = first requester with req high, searching from rr_ptr+1 upward with wrap-around.
  - Next cycle: grant=onehot(winner), state=LOAD.
- LOAD, with req[winner] high:
  - Next cycle: tx_start=1, tx_data=req_data[winner], req_ack[winner]=1, last_r=req_last[winner], timeout counter cleared, state=SEND.
- LOAD, with req[winner] low:
  - If no byte has been sent yet in this packet: grant=0, state=IDLE, no err.
  - Otherwise: err pulse, grant=0, state=GAP.
- Latency: req rising in IDLE at cycle N gives grant at N+1, and tx_start plus req_ack at N+2.
- SEND: tx_done is sampled only in SEND; tx_done in any other state is ignored.
  - tx_done with last_r=0: state=LOAD, grant unchanged.
  - tx_done with last_r=1: grant=0, rr_ptr=winner, state=GAP.
  - Timeout (counter reaches TX_TIMEOUT-1 without tx_done): err pulse, grant=0, rr_ptr=winner, state=GAP.
  - Counter width is clog2(TX_TIMEOUT).
- GAP: counts GAP_CYCLES cycles, then state=IDLE. With GAP_CYCLES=0, SEND goes directly to IDLE.
  - Requests arriving during GAP wait for IDLE and are not lost.
- Fairness: the requester that just finished has lowest priority in the next arbitration.
  - A sole requester may be re-granted after the gap.
  - Simultaneous requests in IDLE are resolved by rr_ptr, not by index.
- At most one req_ack bit and one tx_start are high per cycle; tx_start never occurs outside the LOAD->SEND transition.
- Requests from non-granted requesters during a packet are held off: no ack, no effect on the current packet.

Test Plan:
- Single byte: req[0]=1, req_data=8'h52, req_last=1 at cycle 0 -> grant=001 at cycle 1; tx_start, tx_data=8'h52 and req_ack[0] at cycle 2; tx_done at cycle 156 -> grant=0 at 157; IDLE after 14 gap cycles.
- Round robin: req=3'b111 held, each a one-byte packet, from reset -> grant order 0,1,2,0; each grant follows a 14-cycle gap.
- Multi-byte lock: req[1] sends "R","G","B" (last on "B") while req[0] asserts mid-packet -> three consecutive tx_start with data 8'h52, 8'h47, 8'h42 all under grant=010; grant to 0 only after the gap.
- Timeout: grant requester 2, tx_done never pulsed -> err pulse exactly TX_TIMEOUT cycles after tx_start; grant=0; next arbitration starts from requester 0.
- Withdrawal: requester 0 drops req after its first byte's tx_done -> err pulse, no second tx_start; withdrawal before the first byte -> no err, back to IDLE.
- Reset mid-SEND, plus a spurious tx_done pulsed in IDLE and GAP -> outputs at reset values the cycle after reset; spurious tx_done causes no state change.
